// File: rtl/ram_sdp_sync_if.sv
// Bus bundle for the simple dual-port RAM: write port, read port and status.
// Latency: none (wires only); read data timing is set by the RAM itself.
// Backpressure: none; busy tells the master that requests are being dropped.
interface ram_sdp_sync_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                     cs;
  logic                     wr_en;
  logic [BE_WIDTH-1:0]      be;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     out_en;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     rd_valid;
  logic                     busy;

  // Requester side: drives accesses, observes read data and status
  modport master (
    output cs, wr_en, be, wr_addr, data_in, out_en, rd_addr,
    input  data_out, rd_valid, busy
  );

  // RAM side
  modport slave (
    input  cs, wr_en, be, wr_addr, data_in, out_en, rd_addr,
    output data_out, rd_valid, busy
  );
endinterface

// File: rtl/ram_sdp_sync.sv
// Simple dual-port synchronous RAM with byte enables and a post-reset zeroing sweep.
// Latency: read data and rd_valid appear READ_LATENCY (1 or 2) cycles after the accept edge.
// Backpressure: none; accesses presented while busy (clear sweep) are silently dropped.
module ram_sdp_sync #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic           clk,
  input logic           rst_n,
  ram_sdp_sync_if.slave bus
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;
  // Only 1 and 2 are meaningful; anything larger is treated as 2.
  localparam int RL    = (READ_LATENCY >= 2) ? 2 : 1;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_sweep_cnt;
  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

  logic                     w_busy;
  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_same_addr;
  logic [DATA_WIDTH-1:0]    w_rd_word;

  // Read pipeline: stage RL-1 is the output register
  logic [RL-1:0]                 r_rd_vld;
  logic [RL-1:0][DATA_WIDTH-1:0] r_rd_dat;

  assign w_busy      = (r_state == ST_CLEAR);
  assign w_wr_acc    = bus.cs & bus.wr_en  & ~w_busy;
  assign w_rd_acc    = bus.cs & bus.out_en & ~w_busy;
  assign w_same_addr = (bus.wr_addr == bus.rd_addr);

  // State register; reset lands in CLEAR so the sweep restarts after every reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave CLEAR once the last address has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (r_sweep_cnt == LAST_ADDR) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = RST_STATE;
    endcase
  end

  // Sweep address: advances once per CLEAR cycle and parks at the last address;
  // only reset brings it back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sweep_cnt <= '0;
    end else if (w_busy && (r_sweep_cnt != LAST_ADDR)) begin
      r_sweep_cnt <= r_sweep_cnt + ADDR_ONE;
    end
  end

  // Storage: the sweep has priority over user writes (which are dropped while busy);
  // contents are deliberately not reset so the array maps onto plain RAM
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_sweep_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.be[i]) begin
          r_mem[bus.wr_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
      end
    end
  end

  // Read word: the array already gives old data on a collision; write-first mode
  // overlays the enabled lanes of the incoming write
  always_comb begin
    w_rd_word = r_mem[bus.rd_addr];
    if ((RDW_MODE != 0) && w_wr_acc && w_same_addr) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.be[i]) begin
          w_rd_word[8*i +: 8] = bus.data_in[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline: valid bits always shift, data stages load only behind a valid
  // so the output register holds the last completed read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= '0;
      r_rd_dat <= '0;
    end else begin
      r_rd_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_dat[0] <= w_rd_word;
      end
      for (int k = 1; k < RL; k++) begin
        r_rd_vld[k] <= r_rd_vld[k-1];
        if (r_rd_vld[k-1]) begin
          r_rd_dat[k] <= r_rd_dat[k-1];
        end
      end
    end
  end

  assign bus.data_out = r_rd_dat[RL-1];
  assign bus.rd_valid = r_rd_vld[RL-1];
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_ram_sdp_sync.sv
// Directed bench for ram_sdp_sync: two instances driven identically,
// A = read-first with 1-cycle reads, B = write-first with 2-cycle reads.
module tb_ram_sdp_sync;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        wr_en;
  logic [1:0]  be;
  logic [3:0]  wr_addr;
  logic [15:0] data_in;
  logic        out_en;
  logic [3:0]  rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  ram_sdp_sync_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4)) if_a ();
  ram_sdp_sync_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4)) if_b ();

  assign if_a.cs = cs;           assign if_b.cs = cs;
  assign if_a.wr_en = wr_en;     assign if_b.wr_en = wr_en;
  assign if_a.be = be;           assign if_b.be = be;
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr;
  assign if_a.data_in = data_in; assign if_b.data_in = data_in;
  assign if_a.out_en = out_en;   assign if_b.out_en = out_en;
  assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr;

  ram_sdp_sync #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_a.slave)
  );

  ram_sdp_sync #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until A drops busy (bounded), counting cycles and any rd_valid seen
  task automatic wait_sweep(output int cyc, output int vcnt);
    cyc  = 0;
    vcnt = 0;
    while ((if_a.busy === 1'b1) && (cyc < 40)) begin
      tick();
      cyc++;
      if ((if_a.rd_valid === 1'b1) || (if_b.rd_valid === 1'b1)) vcnt++;
    end
  endtask

  initial begin
    int          cyc;
    int          vcnt;
    logic [5:0]  a_mask;
    logic [5:0]  b_mask;
    logic [15:0] a_d[$];
    logic [15:0] b_d[$];
    logic [15:0] got;

    rst_n   = 1'b0;
    cs      = 1'b0;
    wr_en   = 1'b0;
    be      = 2'b00;
    wr_addr = 4'd0;
    data_in = 16'h0000;
    out_en  = 1'b0;
    rd_addr = 4'd0;

    // Reset state
    tick();
    tick();
    check("rst_busy_a", if_a.busy, 1);
    check("rst_busy_b", if_b.busy, 1);
    check("rst_vld_a", if_a.rd_valid, 0);
    check("rst_vld_b", if_b.rd_valid, 0);
    check("rst_dout_a", if_a.data_out, 0);
    check("rst_dout_b", if_b.data_out, 0);

    // Sweep after release, with a write and a read attempted throughout busy
    rst_n   = 1'b1;
    cs      = 1'b1;
    wr_en   = 1'b1;
    be      = 2'b11;
    wr_addr = 4'd2;
    data_in = 16'hFFFF;
    out_en  = 1'b1;
    rd_addr = 4'd2;
    wait_sweep(cyc, vcnt);
    wr_en  = 1'b0;
    out_en = 1'b0;
    check("sweep_cycles", cyc, 16);
    check("sweep_no_vld", vcnt, 0);
    check("sweep_busy_b", if_b.busy, 0);

    // Back-to-back reads of the whole array: all zero, one pulse per read
    for (int i = 0; i < 16; i++) begin
      out_en  = 1'b1;
      rd_addr = 4'(i);
      tick();
      check($sformatf("clr_vld_a%0d", i), if_a.rd_valid, 1);
      check($sformatf("clr_dat_a%0d", i), if_a.data_out, 0);
      if (i > 0) begin
        check($sformatf("clr_vld_b%0d", i - 1), if_b.rd_valid, 1);
        check($sformatf("clr_dat_b%0d", i - 1), if_b.data_out, 0);
      end
    end
    out_en = 1'b0;
    tick();
    check("clr_vld_b15", if_b.rd_valid, 1);
    check("clr_idle_a", if_a.rd_valid, 0);
    tick();
    check("clr_idle_b", if_b.rd_valid, 0);

    // Chip select low blocks both ports
    cs      = 1'b0;
    wr_en   = 1'b1;
    out_en  = 1'b1;
    wr_addr = 4'd7;
    rd_addr = 4'd7;
    data_in = 16'hBEEF;
    tick();
    check("cs0_vld_a", if_a.rd_valid, 0);
    tick();
    check("cs0_vld_a2", if_a.rd_valid, 0);
    check("cs0_vld_b", if_b.rd_valid, 0);
    cs    = 1'b1;
    wr_en = 1'b0;
    tick();
    check("cs0_mem_a", if_a.data_out, 16'h0000);
    out_en = 1'b0;
    tick();
    check("cs0_mem_b", if_b.data_out, 16'h0000);
    check("cs0_mem_vb", if_b.rd_valid, 1);

    // Full write then read; then a low-lane-only write
    wr_en   = 1'b1;
    be      = 2'b11;
    wr_addr = 4'd3;
    data_in = 16'hA5C3;
    tick();
    wr_en   = 1'b0;
    out_en  = 1'b1;
    rd_addr = 4'd3;
    tick();
    check("wr_full_vld_a", if_a.rd_valid, 1);
    check("wr_full_dat_a", if_a.data_out, 16'hA5C3);
    out_en = 1'b0;
    tick();
    check("hold_vld_a", if_a.rd_valid, 0);
    check("hold_dat_a", if_a.data_out, 16'hA5C3);
    check("wr_full_dat_b", if_b.data_out, 16'hA5C3);
    wr_en   = 1'b1;
    be      = 2'b01;
    data_in = 16'h1234;
    tick();
    wr_en  = 1'b0;
    out_en = 1'b1;
    tick();
    check("wr_lane_dat_a", if_a.data_out, 16'hA534);
    out_en = 1'b0;
    tick();
    check("wr_lane_dat_b", if_b.data_out, 16'hA534);

    // Same-address read during write
    wr_en   = 1'b1;
    be      = 2'b11;
    wr_addr = 4'd5;
    data_in = 16'h1111;
    tick();
    data_in = 16'h2222;
    out_en  = 1'b1;
    rd_addr = 4'd5;
    tick();
    check("rdw_old_a", if_a.data_out, 16'h1111);
    wr_en = 1'b0;
    tick();
    check("rdw_after_a", if_a.data_out, 16'h2222);
    check("rdw_new_b", if_b.data_out, 16'h2222);
    wr_en   = 1'b1;
    be      = 2'b10;
    data_in = 16'h33CC;
    tick();
    check("rdw_part_old_a", if_a.data_out, 16'h2222);
    check("rdw_after_b", if_b.data_out, 16'h2222);
    wr_en = 1'b0;
    tick();
    check("rdw_part_after_a", if_a.data_out, 16'h3322);
    check("rdw_part_merge_b", if_b.data_out, 16'h3322);
    out_en = 1'b0;
    tick();
    check("rdw_part_after_b", if_b.data_out, 16'h3322);

    // Four consecutive reads: pipelined pulses and ordering
    wr_en = 1'b1;
    be    = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 4'(i);
      data_in = 16'(16'h0010 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        out_en  = 1'b1;
        rd_addr = 4'(k);
      end else begin
        out_en = 1'b0;
      end
      tick();
      a_mask[k] = if_a.rd_valid;
      b_mask[k] = if_b.rd_valid;
      if (if_a.rd_valid === 1'b1) a_d.push_back(if_a.data_out);
      if (if_b.rd_valid === 1'b1) b_d.push_back(if_b.data_out);
    end
    check("burst_mask_a", a_mask, 6'b001111);
    check("burst_mask_b", b_mask, 6'b011110);
    for (int j = 0; j < 4; j++) begin
      got = (j < a_d.size()) ? a_d[j] : 16'hxxxx;
      check($sformatf("burst_dat_a%0d", j), got, 16'(16'h0010 + j));
      got = (j < b_d.size()) ? b_d[j] : 16'hxxxx;
      check($sformatf("burst_dat_b%0d", j), got, 16'(16'h0010 + j));
    end

    // Reset with a read in flight on B
    out_en  = 1'b1;
    rd_addr = 4'd1;
    tick();
    check("inflt_dat_a", if_a.data_out, 16'h0011);
    out_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("inflt_rst_dat_a", if_a.data_out, 0);
    check("inflt_rst_dat_b", if_b.data_out, 0);
    check("inflt_rst_vld_a", if_a.rd_valid, 0);
    check("inflt_rst_vld_b", if_b.rd_valid, 0);
    check("inflt_rst_busy", if_a.busy, 1);
    tick();
    tick();
    rst_n = 1'b1;
    wait_sweep(cyc, vcnt);
    check("inflt_sweep_cycles", cyc, 16);
    check("inflt_no_vld", vcnt, 0);

    // Reset at sweep cycle 7, sweep must restart for a full 16 cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    check("mid_busy_pre", if_a.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", if_b.busy, 1);
    check("mid_rst_vld", if_b.rd_valid, 0);
    tick();
    rst_n = 1'b1;
    wait_sweep(cyc, vcnt);
    check("mid_sweep_cycles", cyc, 16);

    // Contents written before the resets are now zero
    out_en  = 1'b1;
    rd_addr = 4'd5;
    tick();
    check("post_clr5_a", if_a.data_out, 0);
    rd_addr = 4'd3;
    tick();
    check("post_clr3_a", if_a.data_out, 0);
    check("post_clr5_b", if_b.data_out, 0);
    check("post_clr5_vb", if_b.rd_valid, 1);
    out_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
